// File: rtl/bus_irq_latch_pkg.sv
// bus_irq_latch shared definitions
// standard bus bundle and register map offsets
package bus_irq_latch_pkg;

  localparam int BUS_AW = 16;
  localparam int BUS_DW = 32;

  typedef struct packed {
    logic              clk;
    logic              reset_l;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
    logic              wr;
    logic              rd;
  } bus_in_t;

  typedef logic [BUS_DW-1:0] bus_out_t;

  localparam int BUS_IN_WIDTH  = $bits(bus_in_t);
  localparam int BUS_OUT_WIDTH = $bits(bus_out_t);

  localparam logic [3:0] OFS_PENDING = 4'h0;
  localparam logic [3:0] OFS_MODE    = 4'h4;
  localparam logic [3:0] OFS_POL     = 4'h8;
  localparam logic [3:0] OFS_FORCE   = 4'hC;

endpackage

// File: rtl/bus_irq_latch_sync.sv
// bus_irq_latch two-flop synchroniser
// one independent 2-stage chain per event line
module bus_irq_latch_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // capture raw lines, then resample to settle metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/irq_latch_cell.sv
// irq_latch_cell: one interrupt source
// prev flop, edge/level select, pending with set-over-clear
module irq_latch_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic pol,
  input  logic mode,
  input  logic armed,
  input  logic w1c,
  input  logic force_set,
  input  logic lvl_to_edge,
  output logic pending
);

  logic prev;
  logic edge_hit;
  logic pend_d;

  // remember last synchronised level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= s;
  end

  // level bits mirror the line; edge bits latch, set beats clear
  always_comb begin
    pend_d   = pending;
    edge_hit = armed && (pol ? (!s && prev) : (s && !prev));
    if (!mode)                      pend_d = s ^ pol;
    else if (edge_hit || force_set) pend_d = 1'b1;
    else if (w1c || lvl_to_edge)    pend_d = 1'b0;
  end

  // pending state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 1'b0;
    else        pending <= pend_d;
  end

endmodule

// File: rtl/bus_irq_latch.sv
// bus_irq_latch top: bus decode, MODE/POL, startup mask
// turns raw event lines into pending bits and active-low requests
module bus_irq_latch
  import bus_irq_latch_pkg::*;
#(
  parameter int          ADDR       = 0,
  parameter int          DATAWIDTH  = 1,
  parameter logic [31:0] MODE_RESET = '0,
  parameter logic [31:0] POL_RESET  = '0
) (
  input  bus_in_t                bus_in,
  output bus_out_t               bus_out,
  input  logic [DATAWIDTH-1:0]   events_in,
  output logic [DATAWIDTH-1:0]   irqs_out_l
);

  localparam int DW = DATAWIDTH;
  localparam logic [BUS_AW-1:0] BASE = BUS_AW'(ADDR);

  logic          bus_clk;
  logic          bus_reset_l;
  logic          in_win;
  logic [3:0]    ofs;
  logic          sel_pend;
  logic          sel_mode;
  logic          sel_pol;
  logic          sel_force;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mode;
  logic [DW-1:0] pol;
  logic [DW-1:0] mode_nxt;
  logic [DW-1:0] pol_nxt;
  logic [DW-1:0] w1c;
  logic [DW-1:0] force_set;
  logic [DW-1:0] lvl_to_edge;
  logic [DW-1:0] s;
  logic [DW-1:0] pending;
  logic [DW-1:0] rdata;
  logic [1:0]    su_cnt;
  logic          armed;
  logic          unused_wdata;

  assign bus_clk     = bus_in.clk;
  assign bus_reset_l = bus_in.reset_l;

  assign in_win = bus_in.addr[BUS_AW-1:4] == BASE[BUS_AW-1:4];
  assign ofs    = bus_in.addr[3:0];

  assign sel_pend  = in_win && (ofs == OFS_PENDING);
  assign sel_mode  = in_win && (ofs == OFS_MODE);
  assign sel_pol   = in_win && (ofs == OFS_POL);
  assign sel_force = in_win && (ofs == OFS_FORCE);

  assign wdata        = bus_in.wdata[DW-1:0];
  assign unused_wdata = ^bus_in.wdata;

  assign mode_nxt  = (bus_in.wr && sel_mode) ? wdata : mode;
  assign pol_nxt   = (bus_in.wr && sel_pol)  ? wdata : pol;
  assign w1c       = (bus_in.wr && sel_pend) ? wdata : '0;
  assign force_set = (bus_in.wr && sel_force) ? wdata : '0;

  // a level bit switched to edge starts clean
  assign lvl_to_edge = mode_nxt & ~mode;
  assign armed       = su_cnt == 2'd3;

  // MODE and POL control registers
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      mode <= MODE_RESET[DW-1:0];
      pol  <= POL_RESET[DW-1:0];
    end else begin
      mode <= mode_nxt;
      pol  <= pol_nxt;
    end
  end

  // hold off edge detection until the synchroniser has filled
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l)        su_cnt <= 2'd0;
    else if (su_cnt != 2'd3) su_cnt <= su_cnt + 2'd1;
  end

  // registered active-low requests to the bridge
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) irqs_out_l <= '1;
    else              irqs_out_l <= ~pending;
  end

  bus_irq_latch_sync #(.W(DW)) u_sync (
    .clk   (bus_clk),
    .rst_n (bus_reset_l),
    .d     (events_in),
    .q     (s)
  );

  for (genvar i = 0; i < DW; i++) begin : g_cell
    irq_latch_cell u_cell (
      .clk         (bus_clk),
      .rst_n       (bus_reset_l),
      .s           (s[i]),
      .pol         (pol[i]),
      .mode        (mode_nxt[i]),
      .armed       (armed),
      .w1c         (w1c[i]),
      .force_set   (force_set[i]),
      .lvl_to_edge (lvl_to_edge[i]),
      .pending     (pending[i])
    );
  end

  // read mux; FORCE and unselected addresses return 0
  always_comb begin
    rdata = '0;
    if (bus_in.rd) begin
      unique case (1'b1)
        sel_pend: rdata = pending;
        sel_mode: rdata = mode;
        sel_pol:  rdata = pol;
        default:  rdata = '0;
      endcase
    end
  end

  assign bus_out = BUS_DW'(rdata);

endmodule
